// File: rtl/corr_seq_ctrl_if.sv
// Sample, control and MAC-bank bundle for corr_seq_ctrl.
// slave = the sequencer itself; master = the front end / bank side that drives its inputs.
interface corr_seq_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DW     = 8,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [CNT_W-1:0]  n_samples;
    logic              busy;
    logic              done;
    logic              s_valid;
    logic [DW-1:0]     s_data;
    logic              s_ready;
    logic              mac_clr;
    logic              mac_sin;
    logic [DW-1:0]     mac_A;
    logic [DW-1:0]     mac_B;
    logic              mac_read;
    logic [ADDR_W-1:0] mac_rAddr;
    logic [ACC_W-1:0]  mac_rData;
    logic              out_valid;
    logic [ADDR_W-1:0] out_bin;
    logic [ACC_W-1:0]  out_data;
    logic              out_last;

    modport slave (
        input  start, n_samples, s_valid, s_data, mac_rData,
        output busy, done, s_ready, mac_clr, mac_sin, mac_A, mac_B,
               mac_read, mac_rAddr, out_valid, out_bin, out_data, out_last
    );

    modport master (
        output start, n_samples, s_valid, s_data, mac_rData,
        input  busy, done, s_ready, mac_clr, mac_sin, mac_A, mac_B,
               mac_read, mac_rAddr, out_valid, out_bin, out_data, out_last
    );
endinterface

// File: rtl/corr_seq_ctrl.sv
// Sequencer for a RAM MAC correlator bank: clears the bank, keeps a circular sample
// history, fires one lag sweep per accepted sample, then streams the accumulated bins out.
module corr_seq_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DW     = 8,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    corr_seq_ctrl_if.slave  bus
);
    localparam int BINS = 2**ADDR_W;
    localparam int PH_W = ADDR_W + 1;
    localparam logic [PH_W-1:0] PH_LAST     = PH_W'(BINS - 1);
    localparam logic [PH_W-1:0] PH_BINS     = PH_W'(BINS);
    localparam logic [PH_W-1:0] PH_READ_END = PH_W'(BINS + 3);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        WAITS,
        MAC,
        READ,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PH_W-1:0]   ph;
    logic [CNT_W-1:0]  n_lat;
    logic [CNT_W-1:0]  smp_cnt;
    logic [ADDR_W-1:0] wptr;
    logic [DW-1:0]     a_lat;

    logic [DW-1:0]     hist [BINS];
    logic [DW-1:0]     hist_q;
    logic              hist_we;
    logic [ADDR_W-1:0] hist_waddr;
    logic [DW-1:0]     hist_wdata;
    logic [ADDR_W-1:0] hist_raddr;

    logic              handshake;
    logic              last_smp;
    logic              sweep_rd;
    logic              ab_valid;
    logic              rd_issue;
    logic [ADDR_W-1:0] rd_addr;
    logic              p1_v;
    logic              p2_v;
    logic [ADDR_W-1:0] p1_bin;
    logic [ADDR_W-1:0] p2_bin;
    logic              out_valid_q;
    logic              out_last_q;
    logic [ADDR_W-1:0] out_bin_q;
    logic [ACC_W-1:0]  out_data_q;

    assign handshake = (state == WAITS) && bus.s_valid;
    assign last_smp  = (smp_cnt == n_lat);
    assign sweep_rd  = (state == MAC) && (ph < PH_BINS);
    assign rd_issue  = (state == READ) && (ph != '0) && (ph <= PH_BINS);
    assign rd_addr   = rd_issue ? ph[ADDR_W-1:0] - ADDR_W'(1) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = CLR;
            CLR:   if (ph == PH_BINS) state_nxt = (n_lat == '0) ? READ : WAITS;
            WAITS: if (bus.s_valid) state_nxt = MAC;
            // The final sweep stays one cycle longer so its last operand pair
            // clears the bank before the read strobe is raised.
            MAC: begin
                if (last_smp) begin
                    if (ph == PH_BINS) state_nxt = READ;
                end else if (ph == PH_LAST) begin
                    state_nxt = WAITS;
                end
            end
            READ:  if (ph == PH_READ_END) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ph          <= '0;
            n_lat       <= '0;
            smp_cnt     <= '0;
            wptr        <= '0;
            a_lat       <= '0;
            ab_valid    <= 1'b0;
            p1_v        <= 1'b0;
            p2_v        <= 1'b0;
            p1_bin      <= '0;
            p2_bin      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_bin_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state <= state_nxt;
            ph    <= (state_nxt != state) ? '0 : ph + PH_W'(1);
            if (state == IDLE && bus.start) begin
                n_lat   <= bus.n_samples;
                smp_cnt <= '0;
            end
            if (state == CLR) begin
                wptr <= '0;
            end else if (handshake) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (handshake) begin
                a_lat   <= bus.s_data;
                smp_cnt <= smp_cnt + CNT_W'(1);
            end
            ab_valid    <= sweep_rd;
            p1_v        <= rd_issue;
            p1_bin      <= rd_addr;
            p2_v        <= p1_v;
            p2_bin      <= p1_bin;
            out_valid_q <= p2_v;
            out_last_q  <= p2_v && (&p2_bin);
            out_bin_q   <= p2_v ? p2_bin : '0;
            out_data_q  <= p2_v ? bus.mac_rData : '0;
        end
    end

    // History RAM: zero-filled during CLR, otherwise written with each accepted sample.
    always_comb begin
        hist_we    = 1'b0;
        hist_waddr = wptr;
        hist_wdata = bus.s_data;
        if (state == CLR) begin
            hist_we    = (ph != '0) && (ph <= PH_BINS);
            hist_waddr = ph[ADDR_W-1:0] - ADDR_W'(1);
            hist_wdata = '0;
        end else if (handshake) begin
            hist_we = 1'b1;
        end
    end

    // wptr already points past the newest sample, so lag k sits at wptr-1-k.
    assign hist_raddr = wptr - ADDR_W'(1) - ph[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (hist_we) hist[hist_waddr] <= hist_wdata;
        hist_q <= hist[hist_raddr];
    end

    assign bus.s_ready   = (state == WAITS);
    assign bus.busy      = (state != IDLE) && (state != DONE);
    assign bus.done      = (state == DONE);
    assign bus.mac_clr   = (state == CLR) && (ph == '0);
    assign bus.mac_sin   = (state == MAC) && (ph == '0);
    assign bus.mac_read  = (state == READ) && (ph <= PH_BINS);
    assign bus.mac_rAddr = rd_addr;
    assign bus.mac_A     = ab_valid ? a_lat : '0;
    assign bus.mac_B     = ab_valid ? hist_q : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_bin   = out_bin_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_corr_seq_ctrl.sv
// Bench for corr_seq_ctrl: behavioural MAC bank with 2-cycle read latency, and a scoreboard
// of lag sums computed directly from the driven samples.
`timescale 1ns/1ps
module tb_corr_seq_ctrl;
    localparam int ADDR_W = 6;
    localparam int DW     = 8;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 16;
    localparam int BINS   = 2**ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] bin;
        logic [ACC_W-1:0]  val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    corr_seq_ctrl_if #(.ADDR_W(ADDR_W), .DW(DW), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    corr_seq_ctrl #(.ADDR_W(ADDR_W), .DW(DW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned viol     = 0;
    int unsigned out_cnt, hs_cnt, clr_cnt, last_cyc;
    exp_t exp_q[$];
    logic [ACC_W-1:0] got [BINS];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // MAC bank model, evaluated mid-cycle on the values the sequencer presents.
    logic [ACC_W-1:0] bank [BINS];
    logic [ACC_W-1:0] rd_s1, rd_s2;
    bit               sweep_on = 1'b0;
    int unsigned      sweep_k  = 0;

    always @(negedge clk) begin
        if (rst) begin
            sweep_on      = 1'b0;
            sweep_k       = 0;
            rd_s1         = '0;
            rd_s2         = '0;
            bus.mac_rData = '0;
        end else begin
            if (int'(bus.mac_clr) + int'(bus.mac_sin) + int'(bus.mac_read) > 1) viol++;
            if (sweep_on && (bus.mac_clr || bus.mac_sin || bus.mac_read)) viol++;
            if (!sweep_on && (bus.mac_A != '0 || bus.mac_B != '0)) viol++;
            bus.mac_rData = rd_s2;
            rd_s2 = rd_s1;
            rd_s1 = bus.mac_read ? bank[bus.mac_rAddr] : '0;
            if (sweep_on) begin
                bank[sweep_k] = bank[sweep_k] + ACC_W'(bus.mac_A) * ACC_W'(bus.mac_B);
                sweep_k++;
                if (sweep_k == BINS) sweep_on = 1'b0;
            end
            if (bus.mac_clr) begin
                for (int i = 0; i < BINS; i++) bank[i] = '0;
            end
            if (bus.mac_sin) begin
                sweep_on = 1'b1;
                sweep_k  = 0;
            end
        end
    end

    // Output scoreboard and event counters.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.s_valid && bus.s_ready) hs_cnt++;
            if (bus.mac_clr) clr_cnt++;
            if (bus.out_last && !bus.out_valid) viol++;
            if (bus.out_valid) begin
                out_cnt++;
                got[bus.out_bin] = bus.out_data;
                if (bus.out_last) last_cyc = cyc;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("out_bin", bus.out_bin, e.bin);
                    check_eq($sformatf("bin%0d_sum", e.bin), bus.out_data, e.val);
                    check_eq($sformatf("bin%0d_last", e.bin), bus.out_last, (e.bin == ADDR_W'(BINS - 1)));
                end
            end
        end
    end

    task automatic check_idle(input string pfx);
        check_eq({pfx, "_busy"}, bus.busy, 0);
        check_eq({pfx, "_done"}, bus.done, 0);
        check_eq({pfx, "_s_ready"}, bus.s_ready, 0);
        check_eq({pfx, "_strobes"}, {bus.mac_clr, bus.mac_sin, bus.mac_read}, 0);
        check_eq({pfx, "_mac_ops"}, {bus.mac_A, bus.mac_B}, 0);
        check_eq({pfx, "_raddr"}, bus.mac_rAddr, 0);
        check_eq({pfx, "_out"}, {bus.out_valid, bus.out_last, bus.out_bin, bus.out_data}, 0);
    endtask

    task automatic wait_ready(input string tag);
        int unsigned t = 0;
        while (!bus.s_ready && t < 4 * BINS) begin
            @(negedge clk);
            t++;
        end
        check_eq(tag, bus.s_ready, 1'b1);
    endtask

    task automatic run_case(input int unsigned n, input logic [DW-1:0] smp[$], input bit hold_valid);
        int unsigned start_cyc, h, h_prev, t;
        logic [ACC_W-1:0] acc;
        out_cnt  = 0;
        hs_cnt   = 0;
        clr_cnt  = 0;
        last_cyc = 0;
        exp_q.delete();
        @(negedge clk);
        bus.n_samples = CNT_W'(n);
        bus.start     = 1'b1;
        start_cyc     = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("clr_pulse", bus.mac_clr, 1'b1);
        check_eq("busy_after_start", bus.busy, 1'b1);
        bus.n_samples = CNT_W'(n + 7);
        if (hold_valid) bus.s_valid = 1'b1;
        @(negedge clk);
        check_eq("clr_width", bus.mac_clr, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        h_prev = 0;
        for (int i = 0; i < int'(n); i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = smp[i];
            wait_ready($sformatf("ready_for_sample%0d", i));
            if (!bus.s_ready) begin
                bus.s_valid = 1'b0;
                return;
            end
            h = cyc;
            if (i == 0) check_eq("first_hs_cycle", h, start_cyc + BINS + 2);
            else        check_eq("hs_spacing", h - h_prev, BINS + 1);
            h_prev = h;
            @(negedge clk);
            if (hold_valid) bus.s_data = DW'($urandom_range(0, 255));
            else            bus.s_valid = 1'b0;
        end
        for (int k = 0; k < BINS; k++) begin
            acc = '0;
            for (int m = k; m < int'(n); m++) acc += ACC_W'(smp[m]) * ACC_W'(smp[m - k]);
            exp_q.push_back({ADDR_W'(k), acc});
        end
        t = 0;
        while (!bus.done && t < 4 * BINS + 64) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_seen", bus.done, 1'b1);
        check_eq("done_after_last", cyc, last_cyc + 1);
        check_eq("busy_at_done", bus.busy, 1'b0);
        @(negedge clk);
        check_eq("done_width", bus.done, 1'b0);
        check_eq("out_count", out_cnt, BINS);
        check_eq("scoreboard_empty", exp_q.size(), 0);
        if (hold_valid) repeat (8) @(negedge clk);
        bus.s_valid = 1'b0;
        check_eq("handshakes", hs_cnt, n);
        check_eq("clr_count", clr_cnt, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] smp[$];
        bus.start     = 1'b0;
        bus.n_samples = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;

        repeat (4) @(negedge clk);
        check_idle("in_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("after_reset");

        smp = '{8'd3};
        run_case(1, smp, 1'b0);
        check_eq("n1_bin0", got[0], 9);
        check_eq("n1_bin1", got[1], 0);

        smp = '{8'd1, 8'd2, 8'd3, 8'd4};
        run_case(4, smp, 1'b0);
        check_eq("n4_bin0", got[0], 30);
        check_eq("n4_bin1", got[1], 20);
        check_eq("n4_bin2", got[2], 11);
        check_eq("n4_bin3", got[3], 4);
        check_eq("n4_bin4", got[4], 0);

        smp.delete();
        for (int i = 0; i < 3; i++) smp.push_back(DW'($urandom_range(1, 255)));
        run_case(3, smp, 1'b1);

        smp.delete();
        run_case(0, smp, 1'b1);

        smp.delete();
        for (int i = 0; i < 600; i++) smp.push_back(8'd255);
        run_case(600, smp, 1'b1);
        check_eq("n600_bin0", got[0], 32'd39015000);
        check_eq("n600_binlast", got[BINS - 1], 32'd34918425);

        // Abort a run in the middle of the second sweep.
        @(negedge clk);
        bus.n_samples = CNT_W'(3);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd5;
        wait_ready("abort_ready0");
        @(negedge clk);
        bus.s_data = 8'd7;
        wait_ready("abort_ready1");
        @(negedge clk);
        bus.s_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("mid_mac_busy", bus.busy, 1'b1);
        check_eq("mid_mac_A", bus.mac_A, 7);
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_abort");

        smp = '{8'd2};
        run_case(1, smp, 1'b0);
        check_eq("rerun_bin0", got[0], 4);
        check_eq("rerun_bin1", got[1], 0);

        repeat (4) @(negedge clk);
        check_eq("bank_protocol", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
